// File: rtl/button_event_ctrl.sv
// button_event_ctrl: per-button press/long-press FSMs feeding one round-robin arbitrated event port.
// Build option: define BUTTON_AUTO_REPEAT_EN for periodic repeat events while a button stays in HOLD.
module button_event_ctrl #(
  parameter  int N_BTN         = 5,
  parameter  int LONG_CYCLES   = 100_000_000,
  parameter  int REPEAT_CYCLES = 20_000_000,
  parameter  int CNT_W         = 27,
  localparam int IDW           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_long,
  output logic [N_BTN-1:0] btn_held
);

  localparam int MAX_LAST = ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) - 1;

  // Reject configurations whose hold timers cannot reach the terminal counts.
  if ((LONG_CYCLES < 1) || (REPEAT_CYCLES < 1) || ($clog2(MAX_LAST + 1) > CNT_W)) begin : g_bad_cfg
    $error("button_event_ctrl: CNT_W too small for LONG_CYCLES/REPEAT_CYCLES");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif
  localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N_BTN);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(N_BTN - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} btn_state_e;

  btn_state_e       state_q [N_BTN];
  btn_state_e       state_d [N_BTN];
  logic [CNT_W-1:0] t_q     [N_BTN];
  logic [CNT_W-1:0] t_d     [N_BTN];

  logic [N_BTN-1:0] s_q;
  logic [N_BTN-1:0] press_pend_q, long_pend_q;
  logic [N_BTN-1:0] press_set, long_set, press_clr, long_clr;
  logic [N_BTN-1:0] held_d, cand;
  logic [IDW-1:0]   rr_q, win, arb_idx;
  logic [IDW:0]     arb_sum;
  logic             found, win_long, load;

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      t_d[i]       = t_q[i];
      press_set[i] = 1'b0;
      long_set[i]  = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (s_q[i]) begin
            state_d[i]   = PRESS;
            t_d[i]       = '0;
            press_set[i] = 1'b1;
          end
        end
        PRESS: begin
          if (!s_q[i]) begin
            state_d[i] = IDLE;
            t_d[i]     = '0;
          end else if (t_q[i] == LONG_LAST) begin
            state_d[i]  = HOLD;
            t_d[i]      = '0;
            long_set[i] = 1'b1;
          end else begin
            t_d[i] = t_q[i] + 1'b1;
          end
        end
        HOLD: begin
          if (!s_q[i]) begin
            state_d[i] = IDLE;
            t_d[i]     = '0;
          end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
            if (t_q[i] == REPEAT_LAST) begin
              t_d[i]      = '0;
              long_set[i] = 1'b1;
            end else begin
              t_d[i] = t_q[i] + 1'b1;
            end
`else
            t_d[i] = '0;
`endif
          end
        end
        default: begin
          state_d[i] = IDLE;
          t_d[i]     = '0;
        end
      endcase
      held_d[i] = (state_d[i] == HOLD);
    end
  end

  // Round-robin search starting at rr_q; rr_q < N_BTN so one wrap subtraction suffices.
  always_comb begin
    cand     = press_pend_q | long_pend_q;
    found    = 1'b0;
    win      = '0;
    win_long = 1'b0;
    arb_sum  = '0;
    arb_idx  = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      arb_sum = {1'b0, rr_q} + (IDW + 1)'(k);
      if (arb_sum >= N_EXT) arb_sum = arb_sum - N_EXT;
      arb_idx = arb_sum[IDW-1:0];
      if (!found && cand[arb_idx]) begin
        found    = 1'b1;
        win      = arb_idx;
        win_long = !press_pend_q[arb_idx];
      end
    end
  end

  assign load = !evt_valid || evt_ready;

  always_comb begin
    press_clr = '0;
    long_clr  = '0;
    if (load && found) begin
      if (win_long) long_clr[win]  = 1'b1;
      else          press_clr[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        t_q[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        t_q[i]     <= t_d[i];
      end
    end
  end

  // Set terms are OR-ed after the clear so a same-cycle set survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q          <= '0;
      press_pend_q <= '0;
      long_pend_q  <= '0;
      btn_held     <= '0;
      rr_q         <= '0;
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_long     <= 1'b0;
    end else begin
      s_q          <= btn_in;
      press_pend_q <= (press_pend_q & ~press_clr) | press_set;
      long_pend_q  <= (long_pend_q & ~long_clr) | long_set;
      btn_held     <= held_d;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id   <= win;
          evt_long <= win_long;
          rr_q     <= (win == LAST_IDX) ? '0 : win + 1'b1;
        end
      end
    end
  end

endmodule
